note_event_recorder: RTL
========================

Name: note_event_recorder

Overview:
- Parametrised successor to the record/playback substate handler.
- Converts a per-key pressed-state vector into timestamped note records with a start time, an end time and an end-valid flag, held in internal storage.
- Pairs each release with its open note through a per-key open-slot table, so no memory scan is needed.
- Closes dangling notes when recording stops, and streams stored notes to the renderer over a valid/ready scan port.

Parameters:
NUM_KEYS, 24, number of key channels
KEY_W, 5, width of key index (ceil log2 NUM_KEYS)
TIME_W, 29, timestamp width in microseconds
DEPTH, 128, note record capacity
ADDR_W, 7, ceil log2 DEPTH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
key_state  in  NUM_KEYS  level, 1 = key held
time_now  in  TIME_W  free-running microsecond counter
record_en  in  1  level, high = recording session active
clear  in  1  pulse, erase all records (honoured in IDLE only)
scan_start  in  1  pulse, begin playback scan (honoured in IDLE only)
scan_ready  in  1  consumer accepts current scan beat
scan_valid  out  1  scan beat valid
scan_key  out  KEY_W  key index of beat
scan_t_start  out  TIME_W  note start time
scan_t_end  out  TIME_W  note end time
scan_len  out  TIME_W  (scan_t_end - scan_t_start) mod 2^TIME_W
scan_done  out  1  one-cycle pulse after last beat accepted
note_count  out  ADDR_W+1  number of stored records
busy  out  1  high in any state other than IDLE
overflow  out  1  sticky, a press was dropped because storage was full

Behaviour:

Reset:
- State becomes IDLE.
- Outputs reset to 0: note_count, overflow, scan_valid, scan_done, and all scan_* fields.
- Internal state resets to 0: the write pointer, the open_valid bits and key_prev.
- The contents of storage are don't-care.

States:
- IDLE, RECORD, CLOSE and SCAN.

IDLE:
- key_prev <= key_state every cycle, so keys already held when recording starts produce no edge.
- Priority: record_en=1 -> RECORD. Else clear=1 -> note_count <= 0, overflow <= 0. Else scan_start=1 with note_count > 0 -> SCAN, rd_ptr <= 0.
- scan_start with note_count = 0: scan_done pulses on the next cycle and state stays IDLE.

RECORD:
- Edge vector = key_state ^ key_prev.
- Each cycle, the lowest-index set edge k is serviced, one event per cycle.
- key_prev[k] <= key_state[k] on the same posedge; other pending edges wait.
- Press (key_state[k]=1):
  - Storage not full: write {k, time_now, end_valid=0} at wr_ptr. Set open_addr[k] <= wr_ptr and open_valid[k] <= 1. Increment wr_ptr and note_count.
  - Storage full (note_count = DEPTH): no write; overflow <= 1.
- Release (key_state[k]=0):
  - open_valid[k]=1: write end time time_now and end_valid=1 at open_addr[k]; open_valid[k] <= 0.
  - Otherwise the release is dropped.
- Press-then-release of the same key within one cycle (prev=0, now=0): no edge, no record.
- Timestamp 0 is legal; openness is indicated by end_valid, never by a zero time.
- record_en=0 -> CLOSE. An edge serviced in that cycle is still committed.

CLOSE:
- Each cycle, the lowest-index key with open_valid set is closed: end = time_now, end_valid=1, open_valid cleared.
- When no open_valid bits remain -> IDLE. With nothing open this takes 1 cycle.
- record_en is ignored in CLOSE.

SCAN:
- scan_valid is registered; the beat at rd_ptr is presented one cycle after entry.
- Beat held stable while scan_valid=1 and scan_ready=0.
- On accept (scan_valid & scan_ready), rd_ptr increments and the next beat is presented on the following cycle; no back-to-back beats are required.
- After the beat at note_count-1 is accepted: scan_valid <= 0, scan_done pulses 1 cycle, state -> IDLE.
- Records with end_valid=0 (unreachable after CLOSE) are emitted with scan_t_end = scan_t_start and scan_len = 0.

Other rules:
- A new RECORD session appends at wr_ptr; only clear resets storage.
- Timestamp arithmetic is modulo 2^TIME_W, so a wrap between start and end yields the correct scan_len.
- Asynchronous reset mid-operation abandons the state immediately; no partial write completes after reset asserts.

Test Plan:
- Reset, record_en=1; press key 3 at time_now=100, release at 350; record_en=0; scan with scan_ready=1 -> one beat: key 3, start 100, end 350, len 250; scan_done pulses; note_count=1.
- In RECORD, keys 2 and 7 rise in the same cycle at t=500 -> key 2 serviced first (start 500), key 7 the next cycle (start 501); note_count=2.
- Hold key 5 from t=1000, drop record_en at t=1200 -> CLOSE writes end=1200 for key 5; scan_len=200; busy falls after CLOSE.
- With DEPTH=4: 5 distinct presses -> note_count=4, overflow=1. The 5th key's release is dropped and no record is corrupted. clear in IDLE -> note_count=0, overflow=0.
- Start time 2^29-10, end time 20 -> scan_len=30. Key held when record_en rises produces no record until it is released and pressed again.
- Scan 3 records with scan_ready held low 4 cycles on beat 1 -> beat 1 fields stable throughout; all 3 beats delivered in order; reset asserted mid-scan -> scan_valid=0 immediately, state IDLE.

Source files
------------

// File: rtl/note_scan_if.sv
// Playback scan port between the note recorder and the renderer.
// The consumer takes a beat on any cycle where scan_valid and scan_ready are both high.
interface note_scan_if #(
    parameter int KEY_W  = 5,
    parameter int TIME_W = 29
);
    logic              scan_valid;
    logic              scan_ready;
    logic [KEY_W-1:0]  scan_key;
    logic [TIME_W-1:0] scan_t_start;
    logic [TIME_W-1:0] scan_t_end;
    logic [TIME_W-1:0] scan_len;
    logic              scan_done;

    modport master (
        output scan_valid, scan_key, scan_t_start, scan_t_end, scan_len, scan_done,
        input  scan_ready
    );

    modport slave (
        input  scan_valid, scan_key, scan_t_start, scan_t_end, scan_len, scan_done,
        output scan_ready
    );
endinterface

// File: rtl/note_event_recorder.sv
// Turns a per-key pressed-state vector into timestamped note records and
// streams them back out over the scan port.
module note_event_recorder #(
    parameter int NUM_KEYS = 24,
    parameter int KEY_W    = 5,
    parameter int TIME_W   = 29,
    parameter int DEPTH    = 128,
    parameter int ADDR_W   = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_state,
    input  logic [TIME_W-1:0]   time_now,
    input  logic                record_en,
    input  logic                clear,
    input  logic                scan_start,
    note_scan_if.master         scan,
    output logic [ADDR_W:0]     note_count,
    output logic                busy,
    output logic                overflow,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_CLOSE  = 2'd2,
        S_SCAN   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [NUM_KEYS-1:0] key_prev;
    logic [NUM_KEYS-1:0] open_valid;
    logic [ADDR_W-1:0]   open_addr [NUM_KEYS];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;

    logic [KEY_W-1:0]  key_mem   [DEPTH];
    logic [TIME_W-1:0] start_mem [DEPTH];
    logic [TIME_W-1:0] end_mem   [DEPTH];
    logic [DEPTH-1:0]  ev_mem;

    logic [NUM_KEYS-1:0] edge_vec;
    logic [NUM_KEYS-1:0] open_rem;
    logic                svc_hit;
    logic [KEY_W-1:0]    svc_key;
    logic                is_press;
    logic                close_hit;
    logic [KEY_W-1:0]    close_key;
    logic                full;
    logic                last_beat;
    logic                new_we;
    logic                end_we;
    logic [ADDR_W-1:0]   end_addr;

    // Lowest-index edge and lowest-index open key are serviced first.
    always_comb begin
        edge_vec  = key_state ^ key_prev;
        svc_hit   = 1'b0;
        svc_key   = '0;
        close_hit = 1'b0;
        close_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (edge_vec[i]) begin
                svc_hit = 1'b1;
                svc_key = KEY_W'(i);
            end
            if (open_valid[i]) begin
                close_hit = 1'b1;
                close_key = KEY_W'(i);
            end
        end
        open_rem = open_valid;
        if (close_hit) open_rem[close_key] = 1'b0;
    end

    always_comb begin
        is_press  = key_state[svc_key];
        full      = (note_count == (ADDR_W + 1)'(DEPTH));
        last_beat = ({1'b0, rd_ptr} == note_count - (ADDR_W + 1)'(1));
        new_we    = (state == S_RECORD) && svc_hit && is_press && !full;
        end_we    = ((state == S_RECORD) && svc_hit && !is_press && open_valid[svc_key]) ||
                    ((state == S_CLOSE) && close_hit);
        end_addr  = (state == S_CLOSE) ? open_addr[close_key] : open_addr[svc_key];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (record_en)
                    state_next = S_RECORD;
                else if (!clear && scan_start && note_count != '0)
                    state_next = S_SCAN;
            end
            S_RECORD: begin
                if (!record_en) state_next = S_CLOSE;
            end
            S_CLOSE: begin
                if (open_rem == '0) state_next = S_IDLE;
            end
            S_SCAN: begin
                if (scan.scan_valid && scan.scan_ready && last_beat) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Storage has no reset; writes are gated by the state, which resets asynchronously.
    always_ff @(posedge clk) begin
        if (new_we) begin
            key_mem[wr_ptr]    <= svc_key;
            start_mem[wr_ptr]  <= time_now;
            ev_mem[wr_ptr]     <= 1'b0;
            open_addr[svc_key] <= wr_ptr;
        end
        if (end_we) begin
            end_mem[end_addr] <= time_now;
            ev_mem[end_addr]  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev          <= '0;
            open_valid        <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            note_count        <= '0;
            overflow          <= 1'b0;
            scan.scan_valid   <= 1'b0;
            scan.scan_done    <= 1'b0;
            scan.scan_key     <= '0;
            scan.scan_t_start <= '0;
            scan.scan_t_end   <= '0;
            scan.scan_len     <= '0;
        end else begin
            scan.scan_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    key_prev <= key_state;
                    if (!record_en) begin
                        if (clear) begin
                            note_count <= '0;
                            overflow   <= 1'b0;
                            wr_ptr     <= '0;
                        end else if (scan_start) begin
                            if (note_count != '0) rd_ptr <= '0;
                            else                  scan.scan_done <= 1'b1;
                        end
                    end
                end
                S_RECORD: begin
                    if (svc_hit) begin
                        key_prev[svc_key] <= key_state[svc_key];
                        if (is_press) begin
                            if (!full) begin
                                open_valid[svc_key] <= 1'b1;
                                wr_ptr              <= wr_ptr + ADDR_W'(1);
                                note_count          <= note_count + (ADDR_W + 1)'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (open_valid[svc_key]) begin
                            open_valid[svc_key] <= 1'b0;
                        end
                    end
                end
                S_CLOSE: begin
                    if (close_hit) open_valid[close_key] <= 1'b0;
                end
                S_SCAN: begin
                    if (!scan.scan_valid) begin
                        // Notes never closed read back as zero-length.
                        scan.scan_valid   <= 1'b1;
                        scan.scan_key     <= key_mem[rd_ptr];
                        scan.scan_t_start <= start_mem[rd_ptr];
                        if (ev_mem[rd_ptr]) begin
                            scan.scan_t_end <= end_mem[rd_ptr];
                            scan.scan_len   <= end_mem[rd_ptr] - start_mem[rd_ptr];
                        end else begin
                            scan.scan_t_end <= start_mem[rd_ptr];
                            scan.scan_len   <= '0;
                        end
                    end else if (scan.scan_ready) begin
                        scan.scan_valid <= 1'b0;
                        if (last_beat) scan.scan_done <= 1'b1;
                        else           rd_ptr <= rd_ptr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
